// File: rtl/instr_encoder_loader.sv
// Packs mnemonic-level instructions into 32-bit MIPS words and streams them into sequential
// instruction-memory words, one registered write per accepted beat.
module instr_encoder_loader #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              finish_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [3:0]        in_op_i,
    input  logic [4:0]        in_rs_i,
    input  logic [4:0]        in_rt_i,
    input  logic [4:0]        in_rd_i,
    input  logic [15:0]       in_imm_i,
    input  logic [25:0]       in_target_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic [ADDR_W:0]   count_o,
    output logic              full_o,
    output logic              done_o,
    output logic              illegal_err_o
);

    typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

    localparam logic [ADDR_W:0]   Capacity = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);

    state_e              state_q, state_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                illegal_q, illegal_d;

    logic                enc_legal;
    logic [31:0]         enc_word;
    logic                full;
    logic                accept;

    always_comb begin
        enc_word  = 32'h0;
        enc_legal = 1'b1;
        case (in_op_i)
            4'd0:    enc_word = {6'b000000, in_rs_i, in_rt_i, in_rd_i, 5'b00000, 6'b100000};
            4'd1:    enc_word = {6'b000000, in_rs_i, in_rt_i, in_rd_i, 5'b00000, 6'b100100};
            4'd2:    enc_word = {6'b000000, in_rs_i, 15'b0, 6'b001000};
            4'd3:    enc_word = {6'b100011, in_rs_i, in_rt_i, in_imm_i};
            4'd4:    enc_word = {6'b101011, in_rs_i, in_rt_i, in_imm_i};
            4'd5:    enc_word = {6'b000100, in_rs_i, in_rt_i, in_imm_i};
            4'd6:    enc_word = {6'b000101, in_rs_i, in_rt_i, in_imm_i};
            4'd7:    enc_word = {6'b000010, in_target_i};
            4'd8:    enc_word = {6'b000011, in_target_i};
            4'd9:    enc_word = {6'b001000, in_rs_i, in_rt_i, in_imm_i};
            4'd10:   enc_word = {6'b001100, in_rs_i, in_rt_i, in_imm_i};
            default: enc_legal = 1'b0;
        endcase
    end

    assign full       = (count_q == Capacity);
    assign in_ready_o = (state_q == StLoad) && !full && !start_i;
    assign accept     = in_valid_i && in_ready_o;

    always_comb begin
        state_d     = state_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        count_d     = count_q;
        illegal_d   = illegal_q;
        if (start_i) begin
            state_d   = StLoad;
            count_d   = '0;
            illegal_d = 1'b0;
        end else begin
            if (accept) begin
                if (enc_legal) begin
                    mem_we_d    = 1'b1;
                    // Address wraps naturally at ADDR_W bits.
                    mem_addr_d  = BaseAddr + count_q[ADDR_W-1:0];
                    mem_wdata_d = enc_word;
                    count_d     = count_q + 1'b1;
                end else begin
                    illegal_d = 1'b1;
                end
            end
            if ((state_q == StLoad) && finish_i) begin
                state_d = StDone;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'h0;
            count_q     <= '0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            count_q     <= count_d;
            illegal_q   <= illegal_d;
        end
    end

    assign mem_we_o      = mem_we_q;
    assign mem_addr_o    = mem_addr_q;
    assign mem_wdata_o   = mem_wdata_q;
    assign count_o       = count_q;
    assign full_o        = full;
    assign done_o        = (state_q == StDone);
    assign illegal_err_o = illegal_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench: a default-size loader and a 4-word loader with a non-zero base address.
module tb_instr_encoder_loader;

    logic        clk;
    logic        rst_n;
    logic        finish;
    logic [3:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [25:0] tgt;

    logic        start_a, valid_a, ready_a, we_a, full_a, done_a, ill_a;
    logic [7:0]  addr_a;
    logic [31:0] wdata_a;
    logic [8:0]  count_a;

    logic        start_b, valid_b, ready_b, we_b, full_b, done_b, ill_b;
    logic [1:0]  addr_b;
    logic [31:0] wdata_b;
    logic [2:0]  count_b;

    int checks = 0;
    int errors = 0;

    instr_encoder_loader #(.ADDR_W(8), .BASE_ADDR(0)) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_a), .finish_i(finish),
        .in_valid_i(valid_a), .in_ready_o(ready_a), .in_op_i(op), .in_rs_i(rs), .in_rt_i(rt),
        .in_rd_i(rd), .in_imm_i(imm), .in_target_i(tgt), .mem_we_o(we_a), .mem_addr_o(addr_a),
        .mem_wdata_o(wdata_a), .count_o(count_a), .full_o(full_a), .done_o(done_a),
        .illegal_err_o(ill_a)
    );

    instr_encoder_loader #(.ADDR_W(2), .BASE_ADDR(2)) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_b), .finish_i(finish),
        .in_valid_i(valid_b), .in_ready_o(ready_b), .in_op_i(op), .in_rs_i(rs), .in_rt_i(rt),
        .in_rd_i(rd), .in_imm_i(imm), .in_target_i(tgt), .mem_we_o(we_b), .mem_addr_o(addr_b),
        .mem_wdata_o(wdata_b), .count_o(count_b), .full_o(full_b), .done_o(done_b),
        .illegal_err_o(ill_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", name, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Drive one beat on dut A, then check the write one cycle later.
    task automatic beat_a(input string name, input logic [3:0] o, input logic [4:0] s,
                          input logic [4:0] t, input logic [4:0] d, input logic [15:0] i,
                          input logic [25:0] g, input logic [31:0] exp_word,
                          input logic [7:0] exp_addr, input logic [8:0] exp_cnt);
        op = o; rs = s; rt = t; rd = d; imm = i; tgt = g; valid_a = 1'b1;
        step();
        chk({name, "_we"}, 32'(we_a), 32'd1);
        chk({name, "_addr"}, 32'(addr_a), 32'(exp_addr));
        chk({name, "_wdata"}, wdata_a, exp_word);
        chk({name, "_count"}, 32'(count_a), 32'(exp_cnt));
    endtask

    initial begin
        rst_n = 1'b0; finish = 1'b0; op = '0; rs = '0; rt = '0; rd = '0; imm = '0; tgt = '0;
        start_a = 1'b0; valid_a = 1'b0; start_b = 1'b0; valid_b = 1'b0;
        step();
        chk("rst_we", 32'(we_a), 32'd0);
        chk("rst_addr", 32'(addr_a), 32'd0);
        chk("rst_wdata", wdata_a, 32'd0);
        chk("rst_count", 32'(count_a), 32'd0);
        chk("rst_full", 32'(full_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_ill", 32'(ill_a), 32'd0);
        chk("rst_ready", 32'(ready_a), 32'd0);
        rst_n = 1'b1;
        step();
        chk("idle_ready", 32'(ready_a), 32'd0);
        start_a = 1'b1;
        #1 chk("start_blocks_ready", 32'(ready_a), 32'd0);
        step();
        start_a = 1'b0;
        #1 chk("load_ready", 32'(ready_a), 32'd1);

        beat_a("add", 4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 32'h00221820, 8'd0, 9'd1);
        valid_a = 1'b0; start_a = 1'b1;
        step();
        chk("restart_we", 32'(we_a), 32'd0);
        chk("restart_count", 32'(count_a), 32'd0);
        start_a = 1'b0;

        beat_a("lw", 4'd3, 5'd0, 5'd8, 5'd0, 16'h0004, 26'h0, 32'h8C080004, 8'd0, 9'd1);
        beat_a("beq", 4'd5, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'h0, 32'h1022FFFF, 8'd1, 9'd2);
        beat_a("j", 4'd7, 5'd17, 5'd0, 5'd0, 16'h0, 26'h0000010, 32'h08000010, 8'd2, 9'd3);
        finish = 1'b1;
        beat_a("addi_fin", 4'd9, 5'd0, 5'd9, 5'd0, 16'h0005, 26'h0, 32'h20090005, 8'd3, 9'd4);
        chk("fin_done", 32'(done_a), 32'd1);
        chk("fin_ready", 32'(ready_a), 32'd0);
        finish = 1'b0; valid_a = 1'b0;
        step();
        chk("done_we", 32'(we_a), 32'd0);
        chk("done_hold", 32'(done_a), 32'd1);

        start_a = 1'b1;
        step();
        start_a = 1'b0;
        chk("redo_done", 32'(done_a), 32'd0);
        beat_a("and", 4'd1, 5'd4, 5'd5, 5'd6, 16'h1234, 26'h0, 32'h00853024, 8'd0, 9'd1);
        beat_a("jr", 4'd2, 5'd31, 5'd7, 5'd9, 16'h1234, 26'h3, 32'h03E00008, 8'd1, 9'd2);
        beat_a("sw", 4'd4, 5'd29, 5'd31, 5'd2, 16'h0010, 26'h0, 32'hAFBF0010, 8'd2, 9'd3);
        beat_a("bne", 4'd6, 5'd3, 5'd0, 5'd0, 16'h8000, 26'h0, 32'h14608000, 8'd3, 9'd4);
        beat_a("jal", 4'd8, 5'd5, 5'd6, 5'd7, 16'h0, 26'h3FFFFFF, 32'h0FFFFFFF, 8'd4, 9'd5);
        beat_a("andi", 4'd10, 5'd2, 5'd3, 5'd0, 16'h00FF, 26'h0, 32'h304300FF, 8'd5, 9'd6);

        op = 4'd12;
        step();
        chk("illegal_we", 32'(we_a), 32'd0);
        chk("illegal_err", 32'(ill_a), 32'd1);
        chk("illegal_count", 32'(count_a), 32'd6);
        valid_a = 1'b0;
        step();
        chk("illegal_sticky", 32'(ill_a), 32'd1);
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        chk("start_clr_ill", 32'(ill_a), 32'd0);
        chk("start_clr_count", 32'(count_a), 32'd0);

        // Small loader: base 2, capacity 4, addresses wrap 2,3,0,1.
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        op = 4'd0; rs = 5'd1; rt = 5'd2; valid_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rd = 5'(i);
            step();
            chk("b_we", 32'(we_b), 32'd1);
            chk("b_addr", 32'(addr_b), 32'((i + 2) % 4));
            chk("b_wdata", wdata_b, 32'h00220020 | (32'(i) << 11));
            chk("b_count", 32'(count_b), 32'(i + 1));
        end
        rd = 5'd4;
        chk("b_full", 32'(full_b), 32'd1);
        chk("b_stall_ready", 32'(ready_b), 32'd0);
        step();
        chk("b_stall_we", 32'(we_b), 32'd0);
        chk("b_stall_count", 32'(count_b), 32'd4);
        valid_b = 1'b0; start_b = 1'b1;
        step();
        start_b = 1'b0;
        #1;
        chk("b_restart_full", 32'(full_b), 32'd0);
        chk("b_restart_count", 32'(count_b), 32'd0);
        chk("b_restart_ready", 32'(ready_b), 32'd1);

        // Reset lands before the beat can be captured: no write may appear.
        step();
        op = 4'd0; rs = 5'd1; rt = 5'd2; rd = 5'd3; valid_a = 1'b1;
        #2 rst_n = 1'b0;
        step();
        chk("rst2_we", 32'(we_a), 32'd0);
        chk("rst2_wdata", wdata_a, 32'd0);
        chk("rst2_count", 32'(count_a), 32'd0);
        chk("rst2_ready", 32'(ready_a), 32'd0);
        rst_n = 1'b1;
        step();
        chk("rst2_idle_we", 32'(we_a), 32'd0);
        chk("rst2_idle_done", 32'(done_a), 32'd0);
        chk("rst2_idle_ready", 32'(ready_a), 32'd0);
        valid_a = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
